// File: rtl/alu_op_ctrl.sv
// Sequences one ALU operation per request: registered operands, LAT settle cycles, condition gating, response hold.
// Response at edge k+LAT after acceptance; held until rsp_ready_i, with req_ready_o low from acceptance to response. Optional macro: ALU_OP_CTRL_COND_EN.
module alu_op_ctrl #(
  parameter int N   = 32,
  parameter int LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_opcode_i,
  input  logic [N-1:0] req_a_i,
  input  logic [N-1:0] req_b_i,
  input  logic [3:0]   req_cond_i,
  input  logic         req_flagw_i,
  output logic [1:0]   alu_opcode_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  input  logic [N-1:0] alu_result_i,
  input  logic [3:0]   alu_flags_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic [3:0]   rsp_flags_o,
  output logic         rsp_exec_o,
  output logic [3:0]   flags_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       flagw_q;
  logic       cond_pass;
  logic       accept, capture, skip;

`ifdef ALU_OP_CTRL_COND_EN
  logic pass_q;
  logic fn, fz, fc, fv;

  // Evaluated against the flag register as it stands before the acceptance edge.
  always_comb begin
    {fn, fz, fc, fv} = flags_o;
    cond_pass = 1'b1;
    case (req_cond_i)
      4'h0: cond_pass = fz;
      4'h1: cond_pass = !fz;
      4'h2: cond_pass = fc;
      4'h3: cond_pass = !fc;
      4'h4: cond_pass = fn;
      4'h5: cond_pass = !fn;
      4'h6: cond_pass = fv;
      4'h7: cond_pass = !fv;
      4'h8: cond_pass = fc && !fz;
      4'h9: cond_pass = !fc || fz;
      4'hA: cond_pass = (fn == fv);
      4'hB: cond_pass = (fn != fv);
      4'hC: cond_pass = !fz && (fn == fv);
      4'hD: cond_pass = fz || (fn != fv);
      default: cond_pass = 1'b1;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^req_cond_i;
  assign cond_pass   = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    skip        = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_OP_CTRL_COND_EN
        // A failed condition spends exactly one cycle here so the response lands at k+1.
        if (!pass_q) begin
          skip    = 1'b1;
          state_d = RESP;
        end else
`endif
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= 4'd0;
      flagw_q      <= 1'b0;
      alu_opcode_o <= '0;
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      rsp_result_o <= '0;
      rsp_flags_o  <= 4'd0;
      rsp_exec_o   <= 1'b0;
      flags_o      <= 4'd0;
`ifdef ALU_OP_CTRL_COND_EN
      pass_q       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_opcode_o <= req_opcode_i;
        alu_a_o      <= req_a_i;
        alu_b_o      <= req_b_i;
        flagw_q      <= req_flagw_i;
        cnt_q        <= cond_pass ? 4'(LAT - 1) : 4'd0;
`ifdef ALU_OP_CTRL_COND_EN
        pass_q       <= cond_pass;
`endif
      end else if (state_q == EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        rsp_result_o <= alu_result_i;
        rsp_flags_o  <= alu_flags_i;
        rsp_exec_o   <= 1'b1;
        if (flagw_q) flags_o <= alu_flags_i;
      end
      if (skip) begin
        rsp_result_o <= '0;
        rsp_flags_o  <= flags_o;
        rsp_exec_o   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Bench for alu_op_ctrl: instance 0 with LAT=1, instance 1 with LAT=4, each driving a combinational ADD/SUB/AND/ORR model.
module tb_alu_op_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_flagw, rsp_valid, rsp_ready, rsp_exec;
  logic [1:0][1:0]  req_opcode, alu_opcode;
  logic [1:0][31:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [1:0][3:0]  req_cond, alu_flags, rsp_flags, flags;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0]  model_flags [2];
  logic [31:0] last_result;
  logic [3:0]  last_rflags;
  logic        last_exec;

  function automatic logic [35:0] alu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      2'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
`ifdef ALU_OP_CTRL_COND_EN
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return 1'b1;
`endif
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_alu
    assign {alu_flags[i], alu_result[i]} = alu_model(alu_opcode[i], alu_a[i], alu_b[i]);
  end

  alu_op_ctrl #(.N(32), .LAT(1)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_opcode_i(req_opcode[0]),
    .req_a_i(req_a[0]), .req_b_i(req_b[0]), .req_cond_i(req_cond[0]), .req_flagw_i(req_flagw[0]),
    .alu_opcode_o(alu_opcode[0]), .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]),
    .alu_result_i(alu_result[0]), .alu_flags_i(alu_flags[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_result_o(rsp_result[0]),
    .rsp_flags_o(rsp_flags[0]), .rsp_exec_o(rsp_exec[0]), .flags_o(flags[0])
  );

  alu_op_ctrl #(.N(32), .LAT(4)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_opcode_i(req_opcode[1]),
    .req_a_i(req_a[1]), .req_b_i(req_b[1]), .req_cond_i(req_cond[1]), .req_flagw_i(req_flagw[1]),
    .alu_opcode_o(alu_opcode[1]), .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]),
    .alu_result_i(alu_result[1]), .alu_flags_i(alu_flags[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_result_o(rsp_result[1]),
    .rsp_flags_o(rsp_flags[1]), .rsp_exec_o(rsp_exec[1]), .flags_o(flags[1])
  );

  // Full transaction on instance d; starts and ends 1 time unit after a rising edge.
  task automatic txn(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] cond, input logic fw, input int stall, input string tag);
    logic [35:0] alu;
    logic        pass, got, bad_rdy;
    logic [31:0] exp_res;
    logic [3:0]  exp_rf;
    int          exp_lat, c;
    n_chk++;
    if (req_ready[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b exp 1", tag, req_ready[d]);
    end
    pass    = cond_ok(cond, model_flags[d]);
    alu     = alu_model(op, a, b);
    exp_lat = pass ? (d == 1 ? 4 : 1) : 1;
    exp_res = pass ? alu[31:0] : 32'd0;
    exp_rf  = pass ? alu[35:32] : model_flags[d];
    req_valid[d] = 1'b1; req_opcode[d] = op; req_a[d] = a; req_b[d] = b;
    req_cond[d] = cond; req_flagw[d] = fw; rsp_ready[d] = (stall == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_opcode[d] = 2'($urandom); req_a[d] = $urandom; req_b[d] = $urandom;
    req_cond[d] = 4'($urandom); req_flagw[d] = 1'($urandom);
    if (pass && fw) model_flags[d] = alu[35:32];
    n_chk++;
    if ({alu_opcode[d], alu_a[d], alu_b[d]} !== {op, a, b}) begin
      n_fail++; $display("FAIL %s alu_regs: got %h/%h/%h exp %h/%h/%h", tag, alu_opcode[d], alu_a[d], alu_b[d], op, a, b);
    end
    c = 0; got = 1'b0; bad_rdy = 1'b0;
    while (c < 40 && !got) begin
      if (req_ready[d]) bad_rdy = 1'b1;
      @(posedge clk); #1; c++;
      if (rsp_valid[d]) got = 1'b1;
    end
    n_chk++;
    if (!got || c != exp_lat || bad_rdy) begin
      n_fail++; $display("FAIL %s latency: got %0d (valid=%b rdy_seen=%b) exp %0d", tag, c, got, bad_rdy, exp_lat);
    end
    n_chk++;
    if ({rsp_result[d], rsp_flags[d], rsp_exec[d]} !== {exp_res, exp_rf, pass}) begin
      n_fail++; $display("FAIL %s response: got res=%h f=%b x=%b exp res=%h f=%b x=%b",
                         tag, rsp_result[d], rsp_flags[d], rsp_exec[d], exp_res, exp_rf, pass);
    end
    n_chk++;
    if (flags[d] !== model_flags[d]) begin
      n_fail++; $display("FAIL %s flags_o: got %b exp %b", tag, flags[d], model_flags[d]);
    end
    last_result = rsp_result[d]; last_rflags = rsp_flags[d]; last_exec = rsp_exec[d];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({rsp_valid[d], req_ready[d], rsp_result[d], rsp_flags[d], rsp_exec[d], alu_opcode[d], alu_a[d], alu_b[d]}
          !== {1'b1, 1'b0, exp_res, exp_rf, pass, op, a, b}) begin
        n_fail++; $display("FAIL %s stall_hold[%0d]: got v=%b r=%b res=%h exp v=1 r=0 res=%h", tag, s,
                           rsp_valid[d], req_ready[d], rsp_result[d], exp_res);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({req_ready[d], rsp_valid[d], alu_a[d], alu_b[d]} !== {1'b1, 1'b0, a, b}) begin
      n_fail++; $display("FAIL %s back_to_idle: got rdy=%b v=%b a=%h exp rdy=1 v=0 a=%h", tag, req_ready[d], rsp_valid[d], alu_a[d], a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({req_ready[d], rsp_valid[d], rsp_exec[d], rsp_result[d], rsp_flags[d], flags[d], alu_opcode[d], alu_a[d], alu_b[d]}
          !== {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 2'd0, 32'd0, 32'd0}) begin
        n_fail++; $display("FAIL reset_state[%0d]: got rdy=%b v=%b x=%b res=%h f=%b a=%h exp 1/0/0/0/0/0", d,
                           req_ready[d], rsp_valid[d], rsp_exec[d], rsp_result[d], flags[d], alu_a[d]);
      end
      model_flags[d] = 4'd0;
    end
    req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    txn(0, 2'd0, 32'd1, 32'd10, 4'hE, 1'b1, 0, "add_1_10");
    n_chk++;
    if ({last_result, last_rflags, flags[0]} !== {32'd11, 4'b0000, 4'b0000}) begin
      n_fail++; $display("FAIL add_1_10_values: got res=%0d f=%b fl=%b exp 11/0000/0000", last_result, last_rflags, flags[0]);
    end
    txn(0, 2'd1, 32'd10, 32'd10, 4'hE, 1'b1, 0, "sub_10_10");
    n_chk++;
    if ({last_result, flags[0]} !== {32'd0, 4'b0110}) begin
      n_fail++; $display("FAIL sub_10_10_values: got res=%0d fl=%b exp 0/0110", last_result, flags[0]);
    end
    txn(0, 2'd0, 32'd2, 32'd3, 4'h0, 1'b0, 0, "eq_add_2_3");
    n_chk++;
    if ({last_exec, last_result} !== {1'b1, 32'd5}) begin
      n_fail++; $display("FAIL eq_add_2_3_values: got x=%b res=%0d exp 1/5", last_exec, last_result);
    end
  endtask

  task automatic test_cond_fail();
    logic exp_x;
`ifdef ALU_OP_CTRL_COND_EN
    exp_x = 1'b0;
`else
    exp_x = 1'b1;
`endif
    txn(0, 2'd0, 32'd1, 32'd1, 4'hE, 1'b1, 0, "clear_z");
    txn(0, 2'd1, 32'd7, 32'd3, 4'h0, 1'b1, 1, "eq_with_z0");
    n_chk++;
    if (last_exec !== exp_x) begin
      n_fail++; $display("FAIL eq_with_z0_exec: got %b exp %b", last_exec, exp_x);
    end
  endtask

  task automatic test_stall();
    txn(1, 2'd3, 32'hF0F0_0000, 32'h0000_0F0F, 4'hF, 1'b1, 5, "lat4_stall5");
    txn(1, 2'd1, 32'd5, 32'd5, 4'hE, 1'b1, 0, "lat4_sub_z");
  endtask

  task automatic test_reset_mid_exec();
    logic seen;
    req_valid[1] = 1'b1; req_opcode[1] = 2'd0; req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'd1;
    req_cond[1] = 4'hE; req_flagw[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_flags[0] = 4'd0; model_flags[1] = 4'd0;
    n_chk++;
    if ({req_ready[1], rsp_valid[1], flags[1]} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL mid_reset_release: got rdy=%b v=%b fl=%b exp 1/0/0000", req_ready[1], rsp_valid[1], flags[1]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[1] || !req_ready[1] || flags[1] != 4'd0) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_quiet: got activity=%b exp 0", seen);
    end
    txn(1, 2'd0, 32'd20, 32'd22, 4'hE, 1'b1, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      txn(i % 4 == 3 ? 1 : 0, 2'($urandom), a, b, 4'($urandom), 1'($urandom),
          $urandom_range(0, 2), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0; req_cond = '0; req_flagw = '0;
    rsp_ready = 2'b11;
    model_flags[0] = 4'd0; model_flags[1] = 4'd0;
    last_result = '0; last_rflags = '0; last_exec = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_cond_fail();
    test_stall();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_ctrl.md
ALU_OP_CTRL -- requirements
Module: alu_op_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, giving the operand and result width in bits.
REQ-002 SHALL have parameter LAT, default 1, legal range 1..15, giving the number of ALU settle cycles before capture.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have these request ports: req_valid_i (in, 1), req_ready_o (out, 1), req_opcode_i (in, 2), req_a_i (in, N), req_b_i (in, N), req_cond_i (in, 4), req_flagw_i (in, 1).
REQ-006 SHALL have these ALU-side ports: alu_opcode_o (out, 2), alu_a_o (out, N), alu_b_o (out, N), alu_result_i (in, N), alu_flags_i (in, 4), with flags ordered {N,Z,C,V}.
REQ-007 SHALL have these response ports: rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_result_o (out, N), rsp_flags_o (out, 4), rsp_exec_o (out, 1), plus flags_o (out, 4) carrying the architectural flag register.

Function
REQ-008 SHALL implement an FSM with states IDLE, EXEC and RESP; req_ready_o SHALL be 1 only in IDLE, and rsp_valid_o SHALL be 1 only in RESP.
REQ-009 In IDLE, when req_valid_i=1 (acceptance edge k), SHALL register opcode, a and b into the alu_* outputs and evaluate req_cond_i against flags_o as it stood before edge k.
REQ-010 Condition codes SHALL be: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E and F always.
REQ-011 When the condition passes, SHALL go to EXEC and load the down-counter with LAT-1.
REQ-012 In EXEC, the counter SHALL decrement once per cycle; at the edge where the counter is 0, SHALL capture alu_result_i into rsp_result_o and alu_flags_i into rsp_flags_o, set rsp_exec_o=1 and go to RESP, so that rsp_valid_o is first high at edge k+LAT.
REQ-013 At the capture edge, if req_flagw_i was 1 at acceptance, SHALL load flags_o from alu_flags_i; otherwise flags_o SHALL stay unchanged.
REQ-014 When the condition fails, SHALL go straight to RESP at edge k+1 with rsp_exec_o=0, rsp_result_o=0, rsp_flags_o=flags_o, and SHALL leave flags_o unchanged regardless of flagw.
REQ-015 In RESP, SHALL hold all rsp_* outputs and alu_* outputs stable until rsp_ready_i=1, then return to IDLE on that edge; a stall of any length is legal.
REQ-016 alu_* outputs SHALL remain stable from acceptance through the end of RESP and SHALL not change in IDLE until the next acceptance.
REQ-017 req_* inputs SHALL be ignored outside IDLE; minimum request spacing is LAT+2 cycles when rsp_ready_i is held at 1.

Reset
REQ-018 While rst_i=1 at a clock edge, SHALL enter IDLE and clear the counter, flags_o, rsp_result_o, rsp_flags_o, rsp_exec_o and all alu_* outputs to 0.
REQ-019 A reset asserted in EXEC or RESP SHALL abort the operation with no response issued and no flag update; req_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-020 Macro ALU_OP_CTRL_COND_EN, when defined, SHALL enable condition evaluation as in REQ-009..REQ-014.
REQ-021 Without ALU_OP_CTRL_COND_EN, every accepted request SHALL execute (rsp_exec_o=1 always), req_cond_i SHALL be ignored, and the REQ-014 path SHALL not exist.

Verification
Bench ALU model: 00 ADD, 01 SUB, 10 AND, 11 ORR, combinational.
REQ-022 Reset, then request opcode 00, a=1, b=10, flagw=1, cond=E -> rsp_valid at edge k+1 (LAT=1), result=11, rsp_flags=0000, flags_o=0000.
REQ-023 Request opcode 01, a=10, b=10, flagw=1 -> result=0, flags {N,Z,C,V}=0110; then cond=0 (EQ), opcode 00, a=2, b=3 -> exec=1, result=5.
REQ-024 With Z=0 in flags_o, request cond=0, flagw=1 -> rsp_exec_o=0, result=0, flags_o unchanged, response at edge k+1 (macro defined); same stimulus without the macro -> exec=1.
REQ-025 LAT=4, rsp_ready_i held 0 for 5 cycles -> rsp_valid_o rises at edge k+4, outputs stay stable, req_ready_o=0 throughout, return to IDLE on the ready edge.
REQ-026 Assert rst_i in the middle of EXEC with LAT=4 -> no rsp_valid_o, flags_o=0, req_ready_o=1 the cycle after release, and the next request completes normally.
